// File: rtl/cgra_im_config_loader.sv
// DTL slave that turns host configuration writes into instruction-memory write strobes.
// Immediate words are 33 bits wide, so each one is packed from two 32-bit beats.
module cgra_im_config_loader #(
  parameter int INTERFACE_WIDTH       = 32,
  parameter int INTERFACE_ADDR_WIDTH  = 32,
  parameter int INTERFACE_BLOCK_WIDTH = 5,
  parameter int I_WIDTH               = 12,
  parameter int I_IMM_WIDTH           = 33,
  parameter int IM_MEM_ADDR_WIDTH     = 8,
  parameter int NUM_ID                = 9,
  parameter int NUM_IMM               = 3
) (
  input  logic                              iClk,
  input  logic                              iReset,
  input  logic                              iDTL_Loader_CommandValid,
  output logic                              oDTL_Loader_CommandAccept,
  input  logic                              iDTL_Loader_CommandReadWrite,
  input  logic [INTERFACE_ADDR_WIDTH-1:0]   iDTL_Loader_Address,
  input  logic [INTERFACE_BLOCK_WIDTH-1:0]  iDTL_Loader_BlockSize,
  input  logic                              iDTL_Loader_WriteValid,
  output logic                              oDTL_Loader_WriteAccept,
  input  logic [INTERFACE_WIDTH-1:0]        iDTL_Loader_WriteData,
  input  logic [INTERFACE_WIDTH/8-1:0]      iDTL_Loader_WriteEnable,
  input  logic                              iDTL_Loader_WriteLast,
  output logic                              oDTL_Loader_ReadValid,
  output logic                              oDTL_Loader_ReadLast,
  output logic [INTERFACE_WIDTH-1:0]        oDTL_Loader_ReadData,
  input  logic                              iDTL_Loader_ReadAccept,
  output logic [NUM_IMM+NUM_ID-1:0]         oIM_WriteEnable,
  output logic [IM_MEM_ADDR_WIDTH-1:0]      oIM_WriteAddress,
  output logic [I_WIDTH-1:0]                oIM_WriteData,
  output logic [I_IMM_WIDTH-1:0]            oIM_WriteData_IMM,
  output logic                              oConfigDone,
  output logic                              oError
);

  localparam int NUM_MEM = NUM_IMM + NUM_ID;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  logic [1:0]                       state_q, state_d;
  logic [INTERFACE_BLOCK_WIDTH-1:0] cnt_q, cnt_d;
  logic                             phase_q, phase_d;
  logic [5:0]                       idx_q, idx_d;
  logic [IM_MEM_ADDR_WIDTH-1:0]     offs_q, offs_d;
  logic [31:0]                      hold_q, hold_d;
  logic [NUM_MEM-1:0]               we_q, we_d;
  logic [IM_MEM_ADDR_WIDTH-1:0]     waddr_q, waddr_d;
  logic [I_WIDTH-1:0]               wdata_q, wdata_d;
  logic [I_IMM_WIDTH-1:0]           wimm_q, wimm_d;
  logic                             done_q, done_d;
  logic                             err_q, err_d;
  logic [NUM_MEM-1:0]               onehot_s;
  logic                             is_imm_s, is_id_s, is_ctrl_s, last_s;
  logic                             unused_s;

  assign unused_s = ^{iDTL_Loader_Address[INTERFACE_ADDR_WIDTH-1:IM_MEM_ADDR_WIDTH+8],
                      iDTL_Loader_Address[1:0]};

  assign is_imm_s  = (idx_q < 6'(NUM_IMM));
  assign is_id_s   = !is_imm_s && (idx_q < 6'(NUM_MEM));
  assign is_ctrl_s = (idx_q == 6'd63);
  assign last_s    = (cnt_q == '0);

  assign oDTL_Loader_CommandAccept = (state_q == S_IDLE) && iDTL_Loader_CommandValid;
  assign oDTL_Loader_WriteAccept   = (state_q == S_WRITE);
  assign oDTL_Loader_ReadValid     = (state_q == S_READ);
  assign oDTL_Loader_ReadLast      = (state_q == S_READ) && last_s;
  assign oDTL_Loader_ReadData      = '0;
  assign oIM_WriteEnable           = we_q;
  assign oIM_WriteAddress          = waddr_q;
  assign oIM_WriteData             = wdata_q;
  assign oIM_WriteData_IMM         = wimm_q;
  assign oConfigDone               = done_q;
  assign oError                    = err_q;

  // Decoded memory index as a one-hot strobe pattern
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      onehot_s[i] = (idx_q == 6'(i));
    end
  end

  // Command decode, beat sequencing and IM write generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    offs_d  = offs_q;
    hold_d  = hold_q;
    we_d    = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wimm_d  = wimm_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (iDTL_Loader_CommandValid) begin
          state_d = iDTL_Loader_CommandReadWrite ? S_READ : S_WRITE;
          cnt_d   = iDTL_Loader_BlockSize;
          phase_d = 1'b0;
          idx_d   = iDTL_Loader_Address[IM_MEM_ADDR_WIDTH+7:IM_MEM_ADDR_WIDTH+2];
          offs_d  = iDTL_Loader_Address[IM_MEM_ADDR_WIDTH+1:2];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (iDTL_Loader_WriteValid) begin
          if (last_s) state_d = S_IDLE;
          else        cnt_d = cnt_q - 1'b1;
          if (iDTL_Loader_WriteLast != last_s) err_d = 1'b1;
          else                                 err_d = err_q;
          // Partial byte enables drop the beat without touching pair phase or offset
          if (iDTL_Loader_WriteEnable != '1) begin
            err_d = 1'b1;
          end else if (is_imm_s) begin
            if (phase_q) begin
              we_d    = onehot_s;
              waddr_d = offs_q;
              wimm_d  = {iDTL_Loader_WriteData[0], hold_q};
              offs_d  = offs_q + 1'b1;
              phase_d = 1'b0;
            end else begin
              hold_d  = iDTL_Loader_WriteData;
              phase_d = 1'b1;
              if (last_s) err_d = 1'b1;
              else        hold_d = iDTL_Loader_WriteData;
            end
          end else if (is_id_s) begin
            we_d    = onehot_s;
            waddr_d = offs_q;
            wdata_d = iDTL_Loader_WriteData[I_WIDTH-1:0];
            offs_d  = offs_q + 1'b1;
          end else if (is_ctrl_s) begin
            if (iDTL_Loader_WriteData[0]) done_d = 1'b1;
            else                          done_d = done_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        if (iDTL_Loader_ReadAccept) begin
          if (last_s) state_d = S_IDLE;
          else        cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      idx_q   <= '0;
      offs_q  <= '0;
      hold_q  <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wimm_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      offs_q  <= offs_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wimm_q  <= wimm_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cgra_im_config_loader.sv
// Directed bench for cgra_im_config_loader: inputs change and outputs are checked on the falling edge.
module tb_cgra_im_config_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_accept, cmd_rw;
  logic [31:0] addr;
  logic [4:0]  bsize;
  logic        wvalid, waccept, wlast;
  logic [31:0] wdata;
  logic [3:0]  wen;
  logic        rvalid, rlast, raccept;
  logic [31:0] rdata;
  logic [11:0] im_we;
  logic [7:0]  im_addr;
  logic [11:0] im_data;
  logic [32:0] im_imm;
  logic        done, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cgra_im_config_loader dut (
    .iClk(clk), .iReset(rst_n),
    .iDTL_Loader_CommandValid(cmd_valid), .oDTL_Loader_CommandAccept(cmd_accept),
    .iDTL_Loader_CommandReadWrite(cmd_rw), .iDTL_Loader_Address(addr),
    .iDTL_Loader_BlockSize(bsize), .iDTL_Loader_WriteValid(wvalid),
    .oDTL_Loader_WriteAccept(waccept), .iDTL_Loader_WriteData(wdata),
    .iDTL_Loader_WriteEnable(wen), .iDTL_Loader_WriteLast(wlast),
    .oDTL_Loader_ReadValid(rvalid), .oDTL_Loader_ReadLast(rlast),
    .oDTL_Loader_ReadData(rdata), .iDTL_Loader_ReadAccept(raccept),
    .oIM_WriteEnable(im_we), .oIM_WriteAddress(im_addr), .oIM_WriteData(im_data),
    .oIM_WriteData_IMM(im_imm), .oConfigDone(done), .oError(err)
  );

  task automatic send_cmd(input logic [31:0] a, input logic [4:0] bs, input logic rw);
    cmd_valid = 1'b1; addr = a; bsize = bs; cmd_rw = rw;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic last);
    wvalid = 1'b1; wdata = d; wlast = last; wen = 4'hF;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; addr = 32'h0; bsize = 5'd0;
    wvalid = 1'b0; wdata = 32'h0; wen = 4'hF; wlast = 1'b0; raccept = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_accept, waccept, rvalid, rlast, done, err} !== 6'b0 || im_we !== 12'h0 ||
        im_addr !== 8'h0 || im_data !== 12'h0 || im_imm !== 33'h0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%h addr=%h data=%h imm=%h done=%b err=%b, required all zero",
               im_we, im_addr, im_data, im_imm, done, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_id_write();
    send_cmd(32'h0000_0C14, 5'd1, 1'b0);
    n_checks++;
    if (waccept !== 1'b1) begin n_fail++; $display("FAIL id_waccept: got %b required 1", waccept); end
    wbeat(32'h0000_0ABC, 1'b0);
    n_checks++;
    if (im_we !== 12'h008 || im_addr !== 8'd5 || im_data !== 12'hABC) begin
      n_fail++; $display("FAIL id_beat0: we=%h addr=%0d data=%h required 008/5/abc", im_we, im_addr, im_data);
    end
    wbeat(32'h0000_0123, 1'b1);
    n_checks++;
    if (im_we !== 12'h008 || im_addr !== 8'd6 || im_data !== 12'h123) begin
      n_fail++; $display("FAIL id_beat1: we=%h addr=%0d data=%h required 008/6/123", im_we, im_addr, im_data);
    end
    @(negedge clk);
    n_checks++;
    if (im_we !== 12'h0 || im_data !== 12'h123 || err !== 1'b0 || waccept !== 1'b0) begin
      n_fail++; $display("FAIL id_after: we=%h data=%h err=%b waccept=%b required 000/123/0/0", im_we, im_data, err, waccept);
    end
  endtask

  task automatic test_imm_write();
    send_cmd(32'h0000_0400, 5'd3, 1'b0);
    wbeat(32'hDEAD_BEEF, 1'b0);
    n_checks++;
    if (im_we !== 12'h0) begin n_fail++; $display("FAIL imm_phase0: we=%h required 000", im_we); end
    wbeat(32'h0000_0001, 1'b0);
    n_checks++;
    if (im_we !== 12'h002 || im_addr !== 8'd0 || im_imm !== 33'h1_DEAD_BEEF) begin
      n_fail++; $display("FAIL imm_word0: we=%h addr=%0d imm=%h required 002/0/1deadbeef", im_we, im_addr, im_imm);
    end
    wbeat(32'h0000_0010, 1'b0);
    n_checks++;
    if (im_we !== 12'h0) begin n_fail++; $display("FAIL imm_phase0b: we=%h required 000", im_we); end
    wbeat(32'h0000_0000, 1'b1);
    n_checks++;
    if (im_we !== 12'h002 || im_addr !== 8'd1 || im_imm !== 33'h0_0000_0010 || err !== 1'b0) begin
      n_fail++; $display("FAIL imm_word1: we=%h addr=%0d imm=%h err=%b required 002/1/000000010/0", im_we, im_addr, im_imm, err);
    end
  endtask

  task automatic test_wrap();
    send_cmd(32'h0000_13FC, 5'd1, 1'b0);
    wbeat(32'h0000_0111, 1'b0);
    n_checks++;
    if (im_we !== 12'h010 || im_addr !== 8'd255 || im_data !== 12'h111) begin
      n_fail++; $display("FAIL wrap_255: we=%h addr=%0d data=%h required 010/255/111", im_we, im_addr, im_data);
    end
    wbeat(32'h0000_0222, 1'b1);
    n_checks++;
    if (im_we !== 12'h010 || im_addr !== 8'd0 || im_data !== 12'h222 || err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_0: we=%h addr=%0d data=%h err=%b required 010/0/222/0", im_we, im_addr, im_data, err);
    end
  endtask

  task automatic test_errors();
    send_cmd(32'h0000_5000, 5'd0, 1'b0);
    wbeat(32'h0000_0005, 1'b1);
    n_checks++;
    if (im_we !== 12'h0 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_invalid_idx: we=%h err=%b required 000/1", im_we, err);
    end
    pulse_reset();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: err=%b required 0", err); end
    send_cmd(32'h0000_0000, 5'd2, 1'b0);
    wbeat(32'h1234_5678, 1'b0);
    wbeat(32'h0000_0000, 1'b0);
    n_checks++;
    if (im_we !== 12'h001 || im_addr !== 8'd0 || im_imm !== 33'h0_1234_5678) begin
      n_fail++; $display("FAIL err_odd_word: we=%h addr=%0d imm=%h required 001/0/012345678", im_we, im_addr, im_imm);
    end
    wbeat(32'h0000_0001, 1'b1);
    n_checks++;
    if (im_we !== 12'h0 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_odd_dangling: we=%h err=%b required 000/1", im_we, err);
    end
    pulse_reset();
    // Partial byte enables: beat dropped, error raised
    send_cmd(32'h0000_0C00, 5'd0, 1'b0);
    wvalid = 1'b1; wdata = 32'h0000_0777; wlast = 1'b1; wen = 4'h7;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; wen = 4'hF;
    n_checks++;
    if (im_we !== 12'h0 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_byte_enable: we=%h err=%b required 000/1", im_we, err);
    end
    pulse_reset();
  endtask

  task automatic test_control_read();
    send_cmd(32'h0000_FC00, 5'd0, 1'b0);
    wbeat(32'h0000_0001, 1'b1);
    n_checks++;
    if (done !== 1'b1 || im_we !== 12'h0 || err !== 1'b0) begin
      n_fail++; $display("FAIL ctrl_done: done=%b we=%h err=%b required 1/000/0", done, im_we, err);
    end
    send_cmd(32'h0000_0000, 5'd2, 1'b1);
    raccept = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rlast !== 1'b0 || cmd_accept !== 1'b0) begin
      n_fail++; $display("FAIL read_stall: rvalid=%b rlast=%b cacc=%b required 1/0/0", rvalid, rlast, cmd_accept);
    end
    for (int i = 0; i < 3; i++) begin
      raccept = 1'b1;
      #1;
      n_checks++;
      if (rvalid !== 1'b1 || rlast !== (i == 2) || rdata !== 32'h0) begin
        n_fail++; $display("FAIL read_beat%0d: rvalid=%b rlast=%b data=%h required 1/%0d/0", i, rvalid, rlast, rdata, i == 2);
      end
      @(negedge clk);
    end
    raccept = 1'b0;
    n_checks++;
    if (rvalid !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL read_end: rvalid=%b done=%b required 0/1", rvalid, done);
    end
  endtask

  task automatic test_reset_mid_burst();
    send_cmd(32'h0000_0000, 5'd1, 1'b0);
    wbeat(32'hCAFE_F00D, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (im_we !== 12'h0 || im_imm !== 33'h0 || im_addr !== 8'h0 || done !== 1'b0 ||
        err !== 1'b0 || waccept !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: we=%h imm=%h done=%b err=%b wacc=%b required zero", im_we, im_imm, done, err, waccept);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wvalid = 1'b1; wdata = 32'h0000_0001; wlast = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    n_checks++;
    if (im_we !== 12'h0) begin n_fail++; $display("FAIL midreset_no_strobe: we=%h required 000", im_we); end
    cmd_valid = 1'b1; addr = 32'h0000_2008; bsize = 5'd0; cmd_rw = 1'b0;
    #1;
    n_checks++;
    if (cmd_accept !== 1'b1) begin n_fail++; $display("FAIL midreset_accept: got %b required 1", cmd_accept); end
    @(negedge clk);
    cmd_valid = 1'b0;
    wbeat(32'h0000_0FED, 1'b1);
    n_checks++;
    if (im_we !== 12'h100 || im_addr !== 8'd2 || im_data !== 12'hFED) begin
      n_fail++; $display("FAIL midreset_next: we=%h addr=%0d data=%h required 100/2/fed", im_we, im_addr, im_data);
    end
  endtask

  initial begin
    test_reset();
    test_id_write();
    test_imm_write();
    test_wrap();
    test_errors();
    test_control_read();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cgra_im_config_loader.md
Name: cgra_im_config_loader

Overview:
- DTL slave that sequences host configuration writes into the CGRA instruction memories: NUM_IMM immediate memories of I_IMM_WIDTH bits and NUM_ID decoder memories of I_WIDTH bits.
- Sits between the host loader DTL port and the instruction-memory write port of the memory block. It decodes the target memory and offset, packs 33-bit immediate words from two DTL beats, and raises oConfigDone on a control write.

Parameters:
- INTERFACE_WIDTH, 32, DTL data width (fixed at 32 for this block).
- INTERFACE_ADDR_WIDTH, 32, DTL byte address width.
- INTERFACE_BLOCK_WIDTH, 5, DTL block size width; burst length in beats = BlockSize+1.
- I_WIDTH, 12, decoder instruction width.
- I_IMM_WIDTH, 33, immediate instruction width (must be 33).
- IM_MEM_ADDR_WIDTH, 8, word address width of each instruction memory.
- NUM_ID, 9, number of decoder memories.
- NUM_IMM, 3, number of immediate memories (NUM_ID+NUM_IMM <= 63).

Ports:
- iClk  in  1  clock.
- iReset  in  1  asynchronous, active-low reset.
- iDTL_Loader_CommandValid  in  1  command request.
- oDTL_Loader_CommandAccept  out  1  command accepted.
- iDTL_Loader_CommandReadWrite  in  1  1=read, 0=write.
- iDTL_Loader_Address  in  INTERFACE_ADDR_WIDTH  byte address.
- iDTL_Loader_BlockSize  in  INTERFACE_BLOCK_WIDTH  beats-1.
- iDTL_Loader_WriteValid  in  1  write beat valid.
- oDTL_Loader_WriteAccept  out  1  write beat accepted.
- iDTL_Loader_WriteData  in  INTERFACE_WIDTH  write beat data.
- iDTL_Loader_WriteEnable  in  INTERFACE_WIDTH/8  byte enables (must be all ones, else beat dropped + error).
- iDTL_Loader_WriteLast  in  1  final write beat marker.
- oDTL_Loader_ReadValid  out  1  read beat valid.
- oDTL_Loader_ReadLast  out  1  final read beat.
- oDTL_Loader_ReadData  out  INTERFACE_WIDTH  read data (always 0).
- iDTL_Loader_ReadAccept  in  1  read beat consumed.
- oIM_WriteEnable  out  NUM_IMM+NUM_ID  one-hot write strobe; bit i = memory index i.
- oIM_WriteAddress  out  IM_MEM_ADDR_WIDTH  word address.
- oIM_WriteData  out  I_WIDTH  decoder instruction.
- oIM_WriteData_IMM  out  I_IMM_WIDTH  immediate instruction.
- oConfigDone  out  1  sticky configuration-complete flag.
- oError  out  1  sticky protocol/address error flag.

Behaviour:
- Reset (iReset=0, async): state IDLE. All outputs 0, holding register 0, counters 0. Reset mid-burst aborts the burst; no partial IM write is issued afterwards.
- Address decode, latched on command accept:
  - mem index = Address[IM_MEM_ADDR_WIDTH+7:IM_MEM_ADDR_WIDTH+2] (6 bits).
  - start offset = Address[IM_MEM_ADDR_WIDTH+1:2].
  - index < NUM_IMM selects an IMM memory; index < NUM_IMM+NUM_ID selects an ID memory; index 63 is the control register; any other index is invalid.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - oDTL_Loader_CommandAccept = CommandValid, combinational, one-cycle accept.
  - On accept, go to WRITE or READ; beat counter = BlockSize; pair phase = 0.
- WRITE:
  - oDTL_Loader_WriteAccept = 1. A beat transfers when WriteValid=1.
  - ID target: the cycle after the beat, oIM_WriteEnable[index]=1 (one cycle), oIM_WriteAddress = offset, oIM_WriteData = WriteData[I_WIDTH-1:0]. Offset then increments.
  - IMM target, phase 0 beat: store WriteData in the holding register, no strobe.
  - IMM target, phase 1 beat: next cycle strobe with oIM_WriteData_IMM = {WriteData[0], hold[31:0]}, then offset increments.
  - Offset wraps modulo 2^IM_MEM_ADDR_WIDTH with no error.
  - Control target: a beat with data bit0=1 sets oConfigDone, which holds until reset.
  - Invalid index: beats are accepted and discarded, and oError is set.
  - When the beat counter reaches 0, return to IDLE.
  - WriteLast disagreeing with the counter sets oError; the counter governs termination.
  - IMM burst ending in phase 1 (odd beat count): the dangling half-word is discarded and oError is set.
  - IM write latency is one cycle after the (final) beat. Strobe data and address are registered and hold their last values when the strobe is low.
- READ (reads are unsupported):
  - ReadValid=1, ReadData=0.
  - A beat completes on ReadAccept. ReadLast=1 on the final beat (counter 0), then return to IDLE.
- No new command is accepted while in WRITE or READ.

Test Plan:
- ID write: Address=(NUM_IMM=3)<<10 | 5<<2, BlockSize=1, data 0xABC, 0x123 -> oIM_WriteEnable=0x008 at addr 5 data 0xABC, then at addr 6 data 0x123, each one cycle after its beat.
- IMM write: index 1, offset 0, BlockSize=3, beats 0xDEADBEEF,1,0x00000010,0 -> enable 0x002: addr 0 data 0x1DEADBEEF, then addr 1 data 0x000000010.
- Wrap: ID index 4, offset 255, BlockSize=1 -> writes at addr 255 then 0; oError stays 0.
- Errors: index 20 write -> no strobe, oError=1; IMM burst of 3 beats -> one write only, oError=1.
- Control/read: write 1 to index 63 -> oConfigDone=1 and held; read BlockSize=2 -> three ReadValid beats of 0, ReadLast on the 3rd; ReadAccept held low stalls ReadValid.
- Reset mid-burst: drop iReset after the IMM phase-0 beat -> no strobe occurs, all outputs 0, IDLE accepts the next command.
